mips_reg_writeback: RTL

Write-side companion to the MIPS register file. It accepts register-write results from the execute/memory stages over a valid/ready handshake, buffers them in a small in-order queue, and drains them one per cycle onto the register file write port (write enable, write register, write data). Optionally, it exposes a combinational bypass lookup so readers see values that are still queued.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mips_wb_fifo.sv | 65 ++++++
 rtl/mips_reg_writeback.sv | 101 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the write-request entry type.
// Optional MIPS_WB_BYPASS_EN adds bypass ports to mips_reg_writeback.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wreg;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/mips_wb_fifo.sv
// In-order write-request queue with wrapping pointers and an occupancy count.
// With MIPS_WB_BYPASS_EN it also exports all entries oldest-first with valid flags.
module mips_wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  wb_req_t       push_dat,
  input  logic          pop,
  output wb_req_t       head,
  output logic [CW-1:0] count
`ifdef MIPS_WB_BYPASS_EN
  ,
  output wb_req_t [DEPTH-1:0] ent,
  output logic    [DEPTH-1:0] ent_vld
`endif
);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];

`ifdef MIPS_WB_BYPASS_EN
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent[k]     = mem[rd_ptr + PW'(k)];
      ent_vld[k] = (CW'(k) < count);
    end
  end
`endif

endmodule

// File: rtl/mips_reg_writeback.sv
// Buffers register-write results and drains one per cycle onto the register file port.
// Optional MIPS_WB_BYPASS_EN adds a two-port lookup of still-pending writes.
module mips_reg_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  output logic              signal_reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [CW-1:0]     pending_count
`ifdef MIPS_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_reg_1,
  input  logic [ADDR_W-1:0] byp_reg_2,
  output logic              byp_hit_1,
  output logic              byp_hit_2,
  output logic [DATA_W-1:0] byp_data_1,
  output logic [DATA_W-1:0] byp_data_2
`endif
);

  wb_req_t push_dat;
  wb_req_t head;
  logic    push;
  logic    pop;

  assign in_ready = (pending_count < CW'(DEPTH));
  // Writes to register 0 finish the handshake but never enter the queue.
  assign push = in_valid && in_ready && (in_reg != ADDR_W'(REG_ZERO)) && !flush;
  assign pop  = (pending_count != '0) && !flush;

  assign push_dat.wreg = REG_ADDR_W'(in_reg);
  assign push_dat.data = REG_DATA_W'(in_data);

`ifdef MIPS_WB_BYPASS_EN
  wb_req_t [DEPTH-1:0] ent;
  logic    [DEPTH-1:0] ent_vld;
`endif

  mips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (pending_count)
`ifdef MIPS_WB_BYPASS_EN
    ,
    .ent      (ent),
    .ent_vld  (ent_vld)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
    end else if (pop) begin
      signal_reg_write <= 1'b1;
      write_reg        <= ADDR_W'(head.wreg);
      write_data       <= DATA_W'(head.data);
    end else begin
      signal_reg_write <= 1'b0;
    end
  end

`ifdef MIPS_WB_BYPASS_EN
  // Output stage is oldest; queue entries are scanned oldest-first so the youngest match wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0] res;
    res = '0;
    if (r != ADDR_W'(REG_ZERO)) begin
      if (signal_reg_write && write_reg == r) res = {1'b1, write_data};
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_vld[k] && ent[k].wreg == REG_ADDR_W'(r)) res = {1'b1, DATA_W'(ent[k].data)};
      end
    end
    return res;
  endfunction

  always_comb begin
    {byp_hit_1, byp_data_1} = lookup(byp_reg_1);
    {byp_hit_2, byp_data_2} = lookup(byp_reg_2);
  end
`endif

endmodule
